// File: rtl/proc_bank_pkg.sv
// Shared types for the operand bank: operation and FSM encodings, index sizing.
package proc_bank_pkg;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_XOR = 2'b01,
    OP_MAX = 2'b10,
    OP_MIN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Index counter width; a one-channel bank would still need a 1-bit index.
  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/reduce_alu.sv
// Combinational reduction step y = f(a, b); carry reports the SUM carry-out only.
// sat_in is the sticky carry of the running reduction, used to hold saturation.
module reduce_alu #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat_in,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  import proc_bank_pkg::*;

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op_e'(op))
      OP_SUM: begin
        carry = sum[WIDTH];
        y     = sum[WIDTH-1:0];
        if ((SATURATE != 0) && (sat_in || sum[WIDTH])) begin
          y = '1;
        end
      end
      OP_XOR: y = a ^ b;
      OP_MAX: y = (a > b) ? a : b;
      OP_MIN: y = (a < b) ? a : b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/proc_node_bank.sv
// Operand bank plus sequential reducer: one channel per clock, result CHANNELS-1 edges after start.
// No backpressure; start is only accepted in IDLE, loads are accepted in every state.
module proc_node_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [CHANNELS-1:0] load_strobe,
  input  logic [1:0]          op,
  input  logic                start,
  output logic                busy,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid,
  output logic                overflow,
  output logic [CHANNELS-1:0] chan_loaded
);
  import proc_bank_pkg::*;

  localparam int            IW       = idx_width(CHANNELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] bank [CHANNELS];
  logic [WIDTH-1:0] snap [CHANNELS];
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  op_e              op_q;
  logic             carry_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (idx == LAST_IDX);

  // Both flags decode the state register directly, so they stay registered outputs.
  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe on the accept edge both reloads the bank and re-marks the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) bank[i] <= '0;
      chan_loaded <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_strobe[i]) bank[i] <= load_data;
      end
      chan_loaded <= (accept ? '0 : chan_loaded) | load_strobe;
    end
  end

  reduce_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .a      (acc),
    .b      (snap[idx]),
    .op     (op_q),
    .sat_in (carry_q),
    .y      (alu_y),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) snap[i] <= '0;
      acc      <= '0;
      idx      <= '0;
      op_q     <= OP_SUM;
      carry_q  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < CHANNELS; i++) snap[i] <= bank[i];
      op_q    <= op_e'(op);
      acc     <= bank[0];
      idx     <= IW'(1);
      carry_q <= 1'b0;
    end else if (state == RUN) begin
      acc     <= alu_y;
      carry_q <= carry_q | alu_carry;
      idx     <= last ? '0 : idx + 1'b1;
      if (last) begin
        result   <= alu_y;
        overflow <= carry_q | alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_proc_node_bank.sv
// Directed bench for proc_node_bank: a wrapping and a saturating instance share all inputs.
module tb_proc_node_bank;
  import proc_bank_pkg::*;

  localparam int LIMIT = 20;

  logic       clk;
  logic       rst_n;
  logic [3:0] load_data;
  logic [3:0] load_strobe;
  logic [1:0] op;
  logic       start;

  logic       busy, result_valid, overflow;
  logic [3:0] result, chan_loaded;
  logic       busy_s, result_valid_s, overflow_s;
  logic [3:0] result_s, chan_loaded_s;

  int n_checks = 0;
  int n_fail   = 0;

  proc_node_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_data    (load_data),
    .load_strobe  (load_strobe),
    .op           (op),
    .start        (start),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .chan_loaded  (chan_loaded)
  );

  proc_node_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1)) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_data    (load_data),
    .load_strobe  (load_strobe),
    .op           (op),
    .start        (start),
    .busy         (busy_s),
    .result       (result_s),
    .result_valid (result_valid_s),
    .overflow     (overflow_s),
    .chan_loaded  (chan_loaded_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int ch, input logic [3:0] d);
    load_strobe = 4'(1 << ch);
    load_data   = d;
    @(posedge clk);
    #1;
    load_strobe = '0;
  endtask

  task automatic load4(input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3);
    load(0, d0);
    load(1, d1);
    load(2, d2);
    load(3, d3);
  endtask

  // One reduction: optional strobe on the start edge, optional strobe on the first RUN edge.
  task automatic reduce(input string tag, input logic [1:0] o,
                        input logic [3:0] st_strobe, input logic [3:0] st_data,
                        input logic [3:0] mid_strobe, input logic [3:0] mid_data);
    int lat;
    int busy_cnt;
    start       = 1'b1;
    op          = o;
    load_strobe = st_strobe;
    load_data   = st_data;
    @(posedge clk);
    #1;
    start       = 1'b0;
    load_strobe = mid_strobe;
    load_data   = mid_data;
    lat         = 0;
    busy_cnt    = 0;
    while (!result_valid && lat < LIMIT) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      load_strobe = '0;
      lat++;
    end
    check({tag, "_timeout"}, 32'(lat >= LIMIT), 32'd0);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
    check({tag, "_sat_valid"}, 32'(result_valid_s), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rv_cnt;
    int first_k;
    int last_k;

    rst_n       = 1'b0;
    load_data   = '0;
    load_strobe = '0;
    op          = '0;
    start       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chan_loaded", 32'(chan_loaded), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3+5+7+2 = 17: wraps to 1, saturates at 15.
    load4(4'd3, 4'd5, 4'd7, 4'd2);
    check("loaded_all", 32'(chan_loaded), 32'hF);
    reduce("sum", OP_SUM, 4'b0, 4'd0, 4'b0, 4'd0);
    check("sum_result", 32'(result), 32'd1);
    check("sum_overflow", 32'(overflow), 32'd1);
    check("sum_sat_result", 32'(result_s), 32'd15);
    check("sum_sat_overflow", 32'(overflow_s), 32'd1);
    check("sum_chan_cleared", 32'(chan_loaded), 32'd0);

    // 3^5^7^2 = 0110^0111^0010 = 0011
    reduce("xor", OP_XOR, 4'b0, 4'd0, 4'b0, 4'd0);
    check("xor_result", 32'(result), 32'd3);
    check("xor_overflow", 32'(overflow), 32'd0);
    check("xor_sat_result", 32'(result_s), 32'd3);
    reduce("max", OP_MAX, 4'b0, 4'd0, 4'b0, 4'd0);
    check("max_result", 32'(result), 32'd7);
    check("max_overflow", 32'(overflow), 32'd0);
    reduce("min", OP_MIN, 4'b0, 4'd0, 4'b0, 4'd0);
    check("min_result", 32'(result), 32'd2);
    check("min_overflow", 32'(overflow_s), 32'd0);

    load4(4'd1, 4'd2, 4'd3, 4'd4);
    reduce("sum10", OP_SUM, 4'b0, 4'd0, 4'b0, 4'd0);
    check("sum10_result", 32'(result), 32'd10);
    check("sum10_sat_result", 32'(result_s), 32'd10);
    check("sum10_sat_overflow", 32'(overflow_s), 32'd0);

    // Channel 2 <- 9 while running: snapshot keeps 3.
    reduce("midload", OP_SUM, 4'b0, 4'd0, 4'b0100, 4'd9);
    check("midload_result", 32'(result), 32'd10);
    check("midload_overflow", 32'(overflow), 32'd0);
    check("midload_chan", 32'(chan_loaded), 32'b0100);
    // 1+2+9+4 = 16
    reduce("after_mid", OP_SUM, 4'b0, 4'd0, 4'b0, 4'd0);
    check("after_mid_result", 32'(result), 32'd0);
    check("after_mid_overflow", 32'(overflow), 32'd1);
    check("after_mid_sat_result", 32'(result_s), 32'd15);

    // start held high: accepts at edges 1, 6, 11 -> valid after edges 4, 9, 14.
    start   = 1'b1;
    op      = OP_MAX;
    rv_cnt  = 0;
    first_k = 0;
    last_k  = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        if (rv_cnt == 0) first_k = k;
        else check("hold_gap", 32'(k - last_k), 32'd5);
        check("hold_result", 32'(result), 32'd9);
        last_k = k;
        rv_cnt++;
      end
    end
    check("hold_first", 32'(first_k), 32'd4);
    check("hold_count", 32'(rv_cnt), 32'd3);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_valid", 32'(result_valid), 32'd0);

    // Same-edge start and strobe of channel 2 <- 0: old 9 is reduced.
    reduce("same_edge", OP_MAX, 4'b0100, 4'd0, 4'b0, 4'd0);
    check("same_edge_result", 32'(result), 32'd9);
    check("same_edge_chan", 32'(chan_loaded), 32'b0100);
    reduce("same_edge_next", OP_MAX, 4'b0, 4'd0, 4'b0, 4'd0);
    check("same_edge_next_result", 32'(result), 32'd4);
    check("same_edge_next_chan", 32'(chan_loaded), 32'd0);

    // Asynchronous reset between clock edges while in RUN.
    start = 1'b1;
    op    = OP_SUM;
    load(1, 4'd6);
    start = 1'b0;
    @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_chan", 32'(chan_loaded), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("arst_no_valid", 32'(result_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    reduce("zero_sum", OP_SUM, 4'b0, 4'd0, 4'b0, 4'd0);
    check("zero_sum_result", 32'(result), 32'd0);
    check("zero_sum_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
